bit_serial_subtractor: RTL and testbench



---
 rtl/bit_serial_subtractor.sv | 139 +++++++++++++
 tb/tb_bit_serial_subtractor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed one bit per clock via a + ~b + 1.
// Optional macro BIT_SERIAL_SUB_ADD_EN adds an 'add' port selecting a + b instead.
module bit_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef BIT_SERIAL_SUB_ADD_EN
  input  logic             add,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             carryout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] eff_b;
  logic             carry_in;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] r_shifted;

  // Effective second operand: inverted b with carry-in 1 subtracts, plain b with carry-in 0 adds.
  always_comb begin
`ifdef BIT_SERIAL_SUB_ADD_EN
    eff_b    = add ? b : ~b;
    carry_in = ~add;
`else
    eff_b    = ~b;
    carry_in = 1'b1;
`endif
  end

  always_comb begin
    sum_bit    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_next = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    r_shifted  = {sum_bit, r_sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    r_sr_d     = r_sr_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    diff_d     = diff_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = a;
          b_sr_d  = eff_b;
          r_sr_d  = '0;
          carry_d = carry_in;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = eff_b[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        r_sr_d  = r_shifted;
        carry_d = carry_next;
        cnt_d   = cnt_q + 1'b1;
        // Results are published only on the final bit so partial sums never appear.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d    = DONE;
          diff_d     = r_shifted;
          carryout_d = carry_next;
          overflow_d = (a_msb_q == b_msb_q) && (r_shifted[WIDTH-1] != a_msb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      r_sr_q     <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_q     <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      r_sr_q     <= r_sr_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      diff_q     <= diff_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor (WIDTH=4) using immediate assertions.
module tb_bit_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             add;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             carryout;
  logic             overflow;

  int n_checks = 0;
  int n_fails  = 0;

  bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef BIT_SERIAL_SUB_ADD_EN
    .add      (add),
`endif
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic exp_busy, input logic exp_done,
                               input logic [WIDTH-1:0] exp_diff, input logic exp_cy,
                               input logic exp_ovf);
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".diff"}, 32'(diff), 32'(exp_diff));
    check({tag, ".carryout"}, 32'(carryout), 32'(exp_cy));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  // One start pulse, then done expected exactly WIDTH edges later and gone one edge after.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic [WIDTH-1:0] prev_diff, input logic prev_cy, input logic prev_ovf,
                        input logic [WIDTH-1:0] exp_diff, input logic exp_cy, input logic exp_ovf);
    start = 1'b1;
    a     = va;
    b     = vb;
    tick();
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    check_outputs({tag, ".accept"}, 1'b1, 1'b0, prev_diff, prev_cy, prev_ovf);
    for (int i = 1; i < WIDTH; i++) tick();
    check_outputs({tag, ".last_shift"}, 1'b1, 1'b0, prev_diff, prev_cy, prev_ovf);
    tick();
    check_outputs({tag, ".done"}, 1'b0, 1'b1, exp_diff, exp_cy, exp_ovf);
    tick();
    check_outputs({tag, ".after"}, 1'b0, 1'b0, exp_diff, exp_cy, exp_ovf);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    add   = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check_outputs("reset", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    run_op("sub_5_3", 4'b0101, 4'b0011, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0);
    run_op("sub_3_5", 4'b0011, 4'b0101, 4'b0010, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0);
    run_op("sub_ovf_neg", 4'b1000, 4'b0001, 4'b1110, 1'b0, 1'b0, 4'b0111, 1'b1, 1'b1);
    run_op("sub_ovf_pos", 4'b0111, 4'b1111, 4'b0111, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1);

    $display("[TB] start held high with operands changed after acceptance");
    start = 1'b1;
    a     = 4'b0101;
    b     = 4'b0011;
    tick();
    a = 4'b0011;
    b = 4'b0101;
    check_outputs("held.accept", 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);
    for (int i = 1; i < WIDTH; i++) tick();
    tick();
    check_outputs("held.done1", 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0);
    tick();
    check_outputs("held.reaccept", 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0);
    tick();
    tick();
    check_outputs("held.stable", 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0);
    tick();
    tick();
    check_outputs("held.done2", 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    check_outputs("held.idle", 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0);

    $display("[TB] reset two cycles into SHIFT");
    start = 1'b1;
    a     = 4'b0101;
    b     = 4'b0011;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_outputs("abort.reset", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      check("abort.no_done", 32'(done), 32'(1'b0));
    end
    run_op("sub_6_6", 4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);

`ifdef BIT_SERIAL_SUB_ADD_EN
    add = 1'b1;
    run_op("add_7_1", 4'b0111, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);
    add = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
